// File: rtl/button_events_pkg.sv
// Shared types and default 12 MHz timing constants for button_events.
package button_events_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOWN1 = 3'd1,
        WAIT2 = 3'd2,
        DOWN2 = 3'd3,
        LONG  = 3'd4
    } state_t;

    localparam int unsigned DEF_COUNT_SIZE   = 24;
    localparam logic [23:0] DEF_LONG_LIMIT   = 24'd12000000;
    localparam logic [23:0] DEF_DOUBLE_LIMIT = 24'd3000000;
    localparam logic [23:0] DEF_REPEAT_LIMIT = 24'd2400000;

    function automatic logic is_held(input state_t s);
        return (s == DOWN1) || (s == DOWN2) || (s == LONG);
    endfunction

endpackage

// File: rtl/event_timer.sv
// Clear/enable timeout counter; saturates at all-ones, done on count == limit-1.
module event_timer #(
    parameter int unsigned COUNT_SIZE = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [COUNT_SIZE-1:0] limit,
    output logic                  done
);

    logic [COUNT_SIZE-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + COUNT_SIZE'(1);
        end
    end

    assign done = (count == (limit - COUNT_SIZE'(1)));

endmodule

// File: rtl/button_events.sv
// Decodes a debounced button level into press/release/click/double/long pulses.
// Optional autorepeat in LONG: define BUTTON_EVENTS_AUTOREPEAT_EN.
module button_events
    import button_events_pkg::*;
#(
    parameter int unsigned          COUNT_SIZE   = DEF_COUNT_SIZE,
    parameter logic [COUNT_SIZE-1:0] LONG_LIMIT   = DEF_LONG_LIMIT,
    parameter logic [COUNT_SIZE-1:0] DOUBLE_LIMIT = DEF_DOUBLE_LIMIT,
    parameter logic [COUNT_SIZE-1:0] REPEAT_LIMIT = DEF_REPEAT_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press,
    output logic release_pulse,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    if ((LONG_LIMIT < COUNT_SIZE'(2)) || (DOUBLE_LIMIT < COUNT_SIZE'(2)) ||
        (REPEAT_LIMIT < COUNT_SIZE'(2))) begin : g_bad_limit
        $error("button_events: every limit must be >= 2");
    end

    state_t state;
    state_t nxt;
    logic   button_q;
    logic   rise;
    logic   fall;
    logic   t_done;
    logic   rep_n;
    logic   press_n;
    logic   rel_n;
    logic   click_n;
    logic   dbl_n;
    logic   long_n;
    logic [COUNT_SIZE-1:0] limit;

    assign rise  = button & ~button_q;
    assign fall  = ~button & button_q;
    assign limit = (state == WAIT2) ? DOUBLE_LIMIT : LONG_LIMIT;

    // Any state change restarts the timeout from zero.
    event_timer #(.COUNT_SIZE(COUNT_SIZE)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (nxt != state),
        .enable (1'b1),
        .limit  (limit),
        .done   (t_done)
    );

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    logic r_done;
    logic r_clear;

    assign r_clear = (state != LONG) || (nxt != LONG) || r_done;
    assign rep_n   = (state == LONG) && !fall && r_done;

    event_timer #(.COUNT_SIZE(COUNT_SIZE)) u_repeat (
        .clock  (clock),
        .reset  (reset),
        .clear  (r_clear),
        .enable (1'b1),
        .limit  (REPEAT_LIMIT),
        .done   (r_done)
    );
`else
    assign rep_n = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        press_n = 1'b0;
        rel_n   = 1'b0;
        click_n = 1'b0;
        dbl_n   = 1'b0;
        long_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    nxt     = DOWN1;
                    press_n = 1'b1;
                end
            end
            DOWN1: begin
                if (fall) begin
                    nxt   = WAIT2;
                    rel_n = 1'b1;
                end else if (t_done) begin
                    nxt    = LONG;
                    long_n = 1'b1;
                end
            end
            WAIT2: begin
                if (rise) begin
                    nxt     = DOWN2;
                    press_n = 1'b1;
                end else if (t_done) begin
                    nxt     = IDLE;
                    click_n = 1'b1;
                end
            end
            DOWN2: begin
                if (fall) begin
                    nxt   = IDLE;
                    rel_n = 1'b1;
                    dbl_n = 1'b1;
                end else if (t_done) begin
                    // First press already completed as a click.
                    nxt     = LONG;
                    click_n = 1'b1;
                    long_n  = 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    nxt   = IDLE;
                    rel_n = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            button_q      <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            click         <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= nxt;
            button_q      <= button;
            press         <= press_n;
            release_pulse <= rel_n;
            click         <= click_n;
            double_click  <= dbl_n;
            long_press    <= long_n;
            repeat_pulse  <= rep_n;
            held          <= is_held(nxt);
        end
    end

endmodule

// File: tb/tb_button_events.sv
// Directed table-driven bench for button_events with short sim limits.
module tb_button_events;

    localparam logic [5:0] P = 6'b100000;
    localparam logic [5:0] R = 6'b010000;
    localparam logic [5:0] C = 6'b001000;
    localparam logic [5:0] D = 6'b000100;
    localparam logic [5:0] L = 6'b000010;
    localparam logic [5:0] N = 6'b000000;

    typedef struct {
        logic       b;
        int         len;
        int         at1;
        logic [5:0] m1;
        int         at2;
        logic [5:0] m2;
    } seg_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic button = 1'b0;
    logic press, release_pulse, click, double_click;
    logic long_press, repeat_pulse, held;

    int checks = 0;
    int errors = 0;
    seg_t tbl [18];

    always #5 clock = ~clock;

    button_events #(
        .COUNT_SIZE   (24),
        .LONG_LIMIT   (24'd100),
        .DOUBLE_LIMIT (24'd40),
        .REPEAT_LIMIT (24'd20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .button        (button),
        .press         (press),
        .release_pulse (release_pulse),
        .click         (click),
        .double_click  (double_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    function automatic logic [6:0] outs();
        return {press, release_pulse, click, double_click,
                long_press, repeat_pulse, held};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s got %b want %b (t=%0t)", name, outs(), exp, $time);
        end
    endtask

    task automatic run_seg(input string name, input seg_t s);
        logic [5:0] m;
        for (int i = 0; i < s.len; i++) begin
            button = s.b;
            @(posedge clock);
            @(negedge clock);
            m = ((i == s.at1) ? s.m1 : N) | ((i == s.at2) ? s.m2 : N);
            check($sformatf("%s[%0d]", name, i), {m, s.b});
        end
    endtask

    initial begin
        tbl = '{
            '{1'b1, 10,  0, P,     -1, N},
            '{1'b0, 60,  0, R,     40, C},
            '{1'b1, 10,  0, P,     -1, N},
            '{1'b0, 20,  0, R,     -1, N},
            '{1'b1, 10,  0, P,     -1, N},
            '{1'b0, 60,  0, R | D, -1, N},
            '{1'b1, 150, 0, P,    100, L},
            '{1'b0, 60,  0, R,     -1, N},
            '{1'b1, 10,  0, P,     -1, N},
            '{1'b0, 40,  0, R,     -1, N},
            '{1'b1, 10,  0, P,     -1, N},
            '{1'b0, 60,  0, R | D, -1, N},
            '{1'b1, 100, 0, P,     -1, N},
            '{1'b0, 60,  0, R,     40, C},
            '{1'b1, 10,  0, P,     -1, N},
            '{1'b0, 10,  0, R,     -1, N},
            '{1'b1, 120, 0, P,    100, C | L},
            '{1'b0, 60,  0, R,     -1, N}
        };

        repeat (3) @(negedge clock);
        check("reset_state", 7'd0);
        reset = 1'b0;

        for (int k = 0; k < 18; k++)
            run_seg($sformatf("tbl%0d", k), tbl[k]);

        // reset while held: outputs clear asynchronously
        run_seg("pre_hold", '{1'b1, 10, 0, P, -1, N});
        reset = 1'b1;
        #1;
        check("async_reset_held", 7'd0);
        @(negedge clock);
        button = 1'b0;
        reset = 1'b0;
        run_seg("post_hold", '{1'b0, 20, -1, N, -1, N});

        // reset 5 cycles into WAIT2 drops the pending click
        run_seg("mid_hi", '{1'b1, 10, 0, P, -1, N});
        run_seg("mid_lo", '{1'b0, 5, 0, R, -1, N});
        reset = 1'b1;
        #1;
        check("async_reset_wait2", 7'd0);
        @(negedge clock);
        reset = 1'b0;
        run_seg("quiet", '{1'b0, 200, -1, N, -1, N});

        // button already high when reset releases yields a press
        button = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        check("reset_btn_high", 7'd0);
        reset = 1'b0;
        run_seg("rel_hi", '{1'b1, 10, 0, P, -1, N});
        run_seg("rel_lo", '{1'b0, 60, 0, R, 40, C});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
